// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: owns the single framebuffer write port. It round-robins the mouse (M)
// and text (T) pixel writers and can take the port exclusively to sweep a full-screen clear.
module fb_write_scheduler #(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              clear_value,
  output logic              clear_busy,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_data,
  output logic              m_ready,
  input  logic              t_valid,
  input  logic [ADDR_W-1:0] t_addr,
  input  logic              t_data,
  output logic              t_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [7:0]        oob_count,
  output logic              dbg_state
);

  localparam logic [ADDR_W:0]   PIX_CNT   = (ADDR_W+1)'(FB_WIDTH * FB_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e            state_q;
  logic              last_grant_t_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_data_q;
  logic [7:0]        oob_count_q;

  logic              accept;
  logic              sel_in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_data;

  // Handshake: a write transfers on a rising edge where valid && ready. Ready depends only on
  // state, clear_start, both valids and last_grant, never on the requester's addr/data.
  always_comb begin
    m_ready = 1'b0;
    t_ready = 1'b0;
    if (state_q == ST_ARB && !clear_start) begin
      if (m_valid && t_valid) begin
        m_ready = last_grant_t_q;
        t_ready = !last_grant_t_q;
      end else begin
        m_ready = m_valid;
        t_ready = t_valid;
      end
    end
  end

  assign accept       = m_ready | t_ready;
  assign sel_addr     = t_ready ? t_addr : m_addr;
  assign sel_data     = t_ready ? t_data : m_data;
  assign sel_in_range = ({1'b0, sel_addr} < PIX_CNT);

  // In CLEAR, wr_addr_q doubles as the sweep counter and wr_data_q holds the latched clear value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ARB;
      last_grant_t_q <= 1'b1;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= 1'b0;
      oob_count_q    <= 8'd0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (clear_start) begin
            state_q   <= ST_CLEAR;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= clear_value;
          end else if (accept) begin
            if (m_valid && t_valid) last_grant_t_q <= t_ready;
            if (sel_in_range) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= sel_addr;
              wr_data_q <= sel_data;
            end else begin
              wr_en_q <= 1'b0;
              if (oob_count_q != 8'hFF) oob_count_q <= oob_count_q + 8'd1;
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (wr_addr_q == LAST_ADDR) begin
            state_q <= ST_ARB;
            wr_en_q <= 1'b0;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign oob_count  = oob_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Testbench for fb_write_scheduler on a reduced 40x30 screen so full clears stay short.
module tb_fb_write_scheduler;
  localparam int FB_W = 40;
  localparam int FB_H = 30;
  localparam int AW   = 19;
  localparam int N    = FB_W * FB_H;
  localparam logic [AW-1:0] A_OOB  = 19'(N);
  localparam logic [AW-1:0] A_LAST = 19'(N - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_start, clear_value, clear_busy;
  logic          m_valid, m_data, m_ready;
  logic [AW-1:0] m_addr;
  logic          t_valid, t_data, t_ready;
  logic [AW-1:0] t_addr;
  logic          wr_en, wr_data;
  logic [AW-1:0] wr_addr;
  logic [7:0]    oob_count;
  logic          dbg_state;

  always #5 clk = ~clk;

  fb_write_scheduler #(.FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .t_valid(t_valid), .t_addr(t_addr), .t_data(t_data), .t_ready(t_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .oob_count(oob_count), .dbg_state(dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: expected port outputs per cycle as {en, addr, data}.
  logic [AW+1:0] exp_q[$];
  logic [AW+1:0] exp_wr;
  logic          exp_m_rdy, exp_t_rdy;
  bit            mdl_last_t;
  int            mdl_oob, mdl_left, mdl_idx;
  logic          mdl_cv;
  logic [AW-1:0] mdl_addr;
  logic          mdl_data;

  task automatic drive(input logic mv, input logic [AW-1:0] ma, input logic md,
                       input logic tv, input logic [AW-1:0] ta, input logic td,
                       input logic cs, input logic cv);
    m_valid = mv; m_addr = ma; m_data = md;
    t_valid = tv; t_addr = ta; t_data = td;
    clear_start = cs; clear_value = cv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back({1'b0, 19'd0, 1'b0});
    mdl_last_t = 1'b1; mdl_oob = 0; mdl_left = 0; mdl_idx = 0;
    mdl_cv = 1'b0; mdl_addr = '0; mdl_data = 1'b0;
  endtask

  task automatic model_eval();
    exp_m_rdy = 1'b0;
    exp_t_rdy = 1'b0;
    if (mdl_left == 0 && !clear_start) begin
      if (m_valid && t_valid) begin
        exp_m_rdy = mdl_last_t;
        exp_t_rdy = !mdl_last_t;
      end else begin
        exp_m_rdy = m_valid;
        exp_t_rdy = t_valid;
      end
    end
    if (exp_q.size() > 0) exp_wr = exp_q.pop_front();
    else exp_wr = {1'b0, mdl_addr, mdl_data};
  endtask

  task automatic model_commit();
    logic en;
    logic [AW-1:0] a;
    en = 1'b0;
    if (mdl_left > 0) begin
      if (mdl_left == 1) mdl_left = 0;
      else begin
        en = 1'b1; mdl_addr = 19'(mdl_idx); mdl_data = mdl_cv;
        mdl_idx++; mdl_left--;
      end
    end else if (clear_start) begin
      en = 1'b1; mdl_addr = '0; mdl_data = clear_value; mdl_cv = clear_value;
      mdl_idx = 1; mdl_left = N;
    end else if (exp_m_rdy || exp_t_rdy) begin
      a = exp_t_rdy ? t_addr : m_addr;
      if (int'(a) < N) begin
        en = 1'b1; mdl_addr = a; mdl_data = exp_t_rdy ? t_data : m_data;
      end else if (mdl_oob < 255) mdl_oob++;
      if (m_valid && t_valid) mdl_last_t = exp_t_rdy;
    end
    exp_q.push_back({en, mdl_addr, mdl_data});
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    tests_run++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 19'd0, 1'b0}) begin
      tests_failed++; $display("FAIL reset_wr got=%h exp=0", {wr_en, wr_addr, wr_data});
    end
    tests_run++;
    if ({clear_busy, oob_count, m_ready, t_ready} !== 11'd0) begin
      tests_failed++; $display("FAIL reset_status busy=%b oob=%0d rdy=%b%b exp all 0",
                               clear_busy, oob_count, m_ready, t_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 19'd1000, 1'b1, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    #2;
    tests_run++;
    if ({m_ready, t_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL single_ready got=%b%b exp=10", m_ready, t_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    #2;
    tests_run++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 19'd1000, 1'b1}) begin
      tests_failed++; $display("FAIL single_wr got en=%b addr=%0d data=%b exp en=1 addr=1000 data=1",
                               wr_en, wr_addr, wr_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ea;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      drive(i < 6, 19'd10, 1'b1, i < 6, 19'd20, 1'b0, 1'b0, 1'b0);
      #2;
      if (i < 6) begin
        tests_run++;
        if ({m_ready, t_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          tests_failed++; $display("FAIL rr_grant cyc=%0d got=%b%b", i, m_ready, t_ready);
        end
      end
      if (i > 0) begin
        ea = ((i - 1) % 2 == 0) ? 19'd10 : 19'd20;
        tests_run++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, ea, ((i - 1) % 2 == 0)}) begin
          tests_failed++; $display("FAIL rr_wr cyc=%0d got en=%b addr=%0d exp addr=%0d",
                                   i, wr_en, wr_addr, ea);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_oob();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 19'd0, 1'b0, 1'b1, A_OOB + 19'(i % 5), 1'b1, 1'b0, 1'b0);
      #2;
      tests_run++;
      if ({t_ready, wr_en} !== 2'b10) begin
        tests_failed++; $display("FAIL oob_ready cyc=%0d t_ready=%b wr_en=%b exp 1,0", i, t_ready, wr_en);
      end
      @(posedge clk); #1;
      tests_run++;
      if (oob_count !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        tests_failed++; $display("FAIL oob_count cyc=%0d got=%0d", i, oob_count);
      end
    end
    drive(1'b0, 19'd0, 1'b0, 1'b1, A_LAST, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    #2;
    tests_run++;
    if ({wr_en, wr_addr, oob_count} !== {1'b1, A_LAST, 8'd255}) begin
      tests_failed++; $display("FAIL oob_last_inrange got en=%b addr=%0d oob=%0d exp 1,%0d,255",
                               wr_en, wr_addr, oob_count, A_LAST);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int stalls;
    stalls = 0;
    do_reset();
    for (int i = 0; i <= N + 2; i++) begin
      drive(1'b1, 19'd77, 1'b1, 1'b0, 19'd0, 1'b0, (i == 0) || (i == 501), (i == 501));
      #2;
      model_eval();
      if (m_ready === 1'b0) stalls++;
      tests_run++;
      if ({m_ready, t_ready} !== {exp_m_rdy, exp_t_rdy}) begin
        tests_failed++; $display("FAIL clr_ready cyc=%0d got=%b%b exp=%b%b", i, m_ready, t_ready, exp_m_rdy, exp_t_rdy);
      end
      tests_run++;
      if ({wr_en, wr_addr, wr_data, clear_busy} !== {exp_wr, mdl_left > 0}) begin
        tests_failed++; $display("FAIL clr_wr cyc=%0d got=%h busy=%b exp=%h busy=%b", i,
                                 {wr_en, wr_addr, wr_data}, clear_busy, exp_wr, mdl_left > 0);
      end
      if (i == N || i == N + 1) begin
        tests_run++;
        if (clear_busy !== (i == N) || (i == N && wr_addr !== A_LAST)) begin
          tests_failed++; $display("FAIL clr_end cyc=%0d busy=%b addr=%0d", i, clear_busy, wr_addr);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
    tests_run++;
    if (stalls != N + 1) begin
      tests_failed++; $display("FAIL clr_stall got=%0d exp=%0d", stalls, N + 1);
    end
    tests_run++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 19'd77, 1'b1}) begin
      tests_failed++; $display("FAIL clr_then_m got en=%b addr=%0d exp 1,77", wr_en, wr_addr);
    end
    drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    for (int k = 0; k <= 346; k++) begin
      drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, k == 0, 1'b1);
      #2;
      model_eval();
      tests_run++;
      if ({wr_en, wr_addr, wr_data, clear_busy} !== {exp_wr, mdl_left > 0}) begin
        tests_failed++; $display("FAIL rmc_wr cyc=%0d got=%h exp=%h", k, {wr_en, wr_addr, wr_data}, exp_wr);
      end
      model_commit();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    tests_run++;
    if ({wr_en, clear_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL rmc_abort wr_en=%b busy=%b exp 0,0", wr_en, clear_busy);
    end
    drive(1'b1, 19'd5, 1'b1, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (m_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rmc_m_ready got=%b exp=1", m_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0);
    #2;
    tests_run++;
    if ({wr_en, wr_addr} !== {1'b1, 19'd5}) begin
      tests_failed++; $display("FAIL rmc_m_wr got en=%b addr=%0d exp 1,5", wr_en, wr_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), 19'($urandom_range(0, N + 40)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 19'($urandom_range(0, N + 40)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)));
      #2;
      model_eval();
      tests_run++;
      if ({m_ready, t_ready} !== {exp_m_rdy, exp_t_rdy}) begin
        tests_failed++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", i, m_ready, t_ready, exp_m_rdy, exp_t_rdy);
      end
      tests_run++;
      if ({wr_en, wr_addr, wr_data, clear_busy, oob_count} !== {exp_wr, mdl_left > 0, 8'(mdl_oob)}) begin
        tests_failed++; $display("FAIL rnd_out cyc=%0d got=%h busy=%b oob=%0d exp=%h busy=%b oob=%0d", i,
                                 {wr_en, wr_addr, wr_data}, clear_busy, oob_count, exp_wr, mdl_left > 0, mdl_oob);
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single write port of the 640x480, 1-bit drawing framebuffer (19-bit linear address = x + y*640).
- Shares that port between two pixel-write requesters: the mouse stroke drawer (M) and the text/glyph renderer (T).
- Contains a full-screen clear engine that takes the port exclusively while it sweeps every address.
- Sits between the input-side pixel generators and the framebuffer RAM. Its registered outputs drive the RAM write pins directly.

Parameters:
- FB_WIDTH, 640, pixels per row.
- FB_HEIGHT, 480, rows.
- ADDR_W, 19, framebuffer address width. Must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- clear_start  in  1  one-cycle pulse that requests a full-screen clear.
- clear_value  in  1  pixel value written by the clear. Sampled on the cycle clear_start is accepted.
- clear_busy  out  1  high while the clear is in progress.
- m_valid  in  1  mouse requester has a pixel write.
- m_addr  in  ADDR_W  mouse pixel address.
- m_data  in  1  mouse pixel value.
- m_ready  out  1  mouse write accepted this cycle.
- t_valid  in  1  text requester has a pixel write.
- t_addr  in  ADDR_W  text pixel address.
- t_data  in  1  text pixel value.
- t_ready  out  1  text write accepted this cycle.
- wr_en  out  1  framebuffer write enable (registered).
- wr_addr  out  ADDR_W  framebuffer write address (registered).
- wr_data  out  1  framebuffer write data (registered).
- oob_count  out  8  count of out-of-range writes that were dropped. Saturates at 255.

Behaviour:
- Reset values: state=ARB, wr_en=0, wr_addr=0, wr_data=0, clear_busy=0, oob_count=0, last_grant=T (so M wins the first tie).
- Reset asserted mid-clear aborts the clear immediately. The next cycle shows clear_busy=0 and wr_en=0.
- States:
  - ARB: arbitration between M and T.
  - CLEAR: exclusive sweep of the framebuffer.
- ARB, ready generation (combinational):
  - If clear_start=1: m_ready=t_ready=0, next state=CLEAR, clear counter loads 0, clear_value is latched.
  - Else if only one valid is high: that requester's ready=1.
  - Else if both valids are high: round-robin. The requester not in last_grant gets ready=1, and last_grant updates to it.
  - Else: both readies are 0.
  - Ready never depends on the requester's own data or address. Valid may be held for any number of cycles with stable addr/data.
- Transfer: valid&&ready on edge N produces wr_en=1 with that requester's addr/data on cycle N+1. Latency is 1, throughput is one write per cycle.
- Out of range: an accepted address >= FB_WIDTH*FB_HEIGHT (307200) still gets ready=1 but produces wr_en=0. oob_count increments, saturating at 255.
- No accepted write produces wr_en=0 on the next cycle. wr_addr and wr_data hold their previous values.
- CLEAR:
  - m_ready=t_ready=0 throughout. clear_busy=1 from the cycle after clear_start through the last write.
  - Emits wr_en=1, wr_addr=0,1,...,307199 on consecutive cycles, with wr_data=latched clear_value. That is 307200 write cycles.
  - After address 307199 is issued, the next cycle is ARB with clear_busy=0. last_grant is unchanged.
- clear_start while in CLEAR is ignored. There is no restart and no queuing.
- clear_start on the same cycle as an M or T valid: the clear wins. The requester stays stalled and is served after the clear.
- The address counter is ADDR_W bits and never wraps past 307199.

Test Plan:
- Reset, then idle: wr_en=0, oob_count=0, clear_busy=0. m_valid=1, m_addr=1000, m_data=1 -> m_ready=1 the same cycle; next cycle wr_en=1, wr_addr=1000, wr_data=1.
- m_valid and t_valid held high for 6 cycles, m_addr=10, t_addr=20 -> grants alternate M,T,M,T,M,T; wr_addr sequence is 10,20,10,20,10,20 with no gaps.
- t_valid=1, t_addr=307200 -> t_ready=1, wr_en stays 0, oob_count=1. Repeat 300 times -> oob_count=255.
- clear_start=1, clear_value=0, with m_valid=1 in the same cycle -> m_ready=0 for 307201 cycles. wr_addr runs 0..307199 with wr_data=0. clear_busy falls, then M is served with wr_addr=its address.
- clear_start pulsed again at clear address 5000 -> sweep continues unaffected and ends at 307199.
- rst asserted at clear address 12345 -> next cycle wr_en=0 and clear_busy=0. m_valid=1 afterwards -> m_ready=1 immediately.
